// File: rtl/mul32_pipelined.sv
// mul32_pipelined: 8-stage 32x32 multiplier using a Dadda tree and a split final adder.
// Signed (Baugh-Wooley) mode is compiled in only when MUL32_SIGNED_MODE_EN is defined.
module mul32_pipelined #(
    parameter real T = 0.0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        mode,
    output logic [31:0] lo,
    output logic [31:0] hi
);
    typedef logic [32:0] col_t;
    typedef col_t [63:0] mat_t;

    // Registers update with zero delay in this model.
    localparam real T_UNUSED = T;

    function automatic int init_h(int c);
        if (c < 32) return c + 1;
        if (c == 32) return 32;
        if (c < 63) return 63 - c;
        return 1;
    endfunction

    function automatic int dseq(int s);
        case (s)
            0: return 28;
            1: return 19;
            2: return 13;
            3: return 9;
            4: return 6;
            5: return 4;
            6: return 3;
            default: return 2;
        endcase
    endfunction

    // Baugh-Wooley: invert mixed-sign terms, add 1 at bit 32 and bit 63.
    function automatic mat_t gen_pp(logic [31:0] x, logic [31:0] y, logic s);
        mat_t m;
        int   h [64];
        int   cc;
        logic bv;
        m = '0;
        for (int c = 0; c < 64; c++) h[6'(c)] = 0;
        for (int i = 0; i < 32; i++) begin
            for (int j = 0; j < 32; j++) begin
                cc = i + j;
                bv = x[5'(j)] & y[5'(i)];
                if ((i == 31) != (j == 31)) bv = bv ^ s;
                m[6'(cc)][6'(h[6'(cc)])] = bv;
                h[6'(cc)] = h[6'(cc)] + 1;
            end
        end
        m[32][31] = s;
        m[63][0]  = s;
        return m;
    endfunction

    // Runs Dadda steps first..last; heights are tracked from the start.
    function automatic mat_t reduce(mat_t m, int first, int last);
        mat_t w, n;
        int   h [64];
        int   nh [64];
        int   tot, k, d;
        logic sm, cy;
        w = '0;
        for (int c = 0; c < 64; c++) h[6'(c)] = init_h(c);
        for (int s = 0; s <= last; s++) begin
            if (s == first) w = m;
            d = dseq(s);
            n = '0;
            for (int c = 0; c < 64; c++) nh[6'(c)] = 0;
            for (int c = 0; c < 64; c++) begin
                tot = h[6'(c)] + nh[6'(c)];
                k = 0;
                for (int r = 0; r < 16; r++) begin
                    if (tot > d) begin
                        if (tot == d + 1) begin
                            sm = w[6'(c)][6'(k)] ^ w[6'(c)][6'(k+1)];
                            cy = w[6'(c)][6'(k)] & w[6'(c)][6'(k+1)];
                            k = k + 2;
                            tot = tot - 1;
                        end else begin
                            sm = w[6'(c)][6'(k)] ^ w[6'(c)][6'(k+1)]
                               ^ w[6'(c)][6'(k+2)];
                            cy = (w[6'(c)][6'(k)] & w[6'(c)][6'(k+1)])
                               | (w[6'(c)][6'(k)] & w[6'(c)][6'(k+2)])
                               | (w[6'(c)][6'(k+1)] & w[6'(c)][6'(k+2)]);
                            k = k + 3;
                            tot = tot - 2;
                        end
                        n[6'(c)][6'(nh[6'(c)])] = sm;
                        nh[6'(c)] = nh[6'(c)] + 1;
                        if (c < 63) begin
                            n[6'(c+1)][6'(nh[6'(c+1)])] = cy;
                            nh[6'(c+1)] = nh[6'(c+1)] + 1;
                        end
                    end
                end
                for (int r = 0; r < 33; r++) begin
                    if (k < h[6'(c)]) begin
                        n[6'(c)][6'(nh[6'(c)])] = w[6'(c)][6'(k)];
                        nh[6'(c)] = nh[6'(c)] + 1;
                        k = k + 1;
                    end
                end
            end
            w = n;
            h = nh;
        end
        return w;
    endfunction

    function automatic logic [127:0] cpa_rows(mat_t m);
        mat_t         f;
        logic [127:0] r;
        f = reduce(m, 6, 7);
        r = '0;
        for (int c = 0; c < 64; c++) begin
            r[7'(c)]    = f[6'(c)][0];
            r[7'(c+64)] = f[6'(c)][1];
        end
        return r;
    endfunction

    logic sgn_d;
`ifdef MUL32_SIGNED_MODE_EN
    assign sgn_d = mode;
`else
    logic unused_mode;
    assign sgn_d = 1'b0;
    assign unused_mode = mode;
`endif

    logic [31:0] a_q, b_q;
    logic        sgn_q;
    mat_t        s2_q, s3_q, s4_q, s5_q;
    logic [63:0] r0_q, r1_q;
    logic [31:0] lo7_q, h0_q, h1_q;
    logic        c7_q;
    logic [31:0] lo_q, hi_q;

    mat_t         pp, red3, red4, red5;
    logic [127:0] rows;
    logic [32:0]  sum_lo;

    always_comb begin
        pp     = gen_pp(a_q, b_q, sgn_q);
        red3   = reduce(s2_q, 0, 1);
        red4   = reduce(s3_q, 2, 3);
        red5   = reduce(s4_q, 4, 5);
        rows   = cpa_rows(s5_q);
        sum_lo = {1'b0, r0_q[31:0]} + {1'b0, r1_q[31:0]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            sgn_q <= 1'b0;
            s2_q  <= '0;
            s3_q  <= '0;
            s4_q  <= '0;
            s5_q  <= '0;
            r0_q  <= '0;
            r1_q  <= '0;
            lo7_q <= '0;
            h0_q  <= '0;
            h1_q  <= '0;
            c7_q  <= 1'b0;
            lo_q  <= '0;
            hi_q  <= '0;
        end else begin
            a_q   <= a;
            b_q   <= b;
            sgn_q <= sgn_d;
            s2_q  <= pp;
            s3_q  <= red3;
            s4_q  <= red4;
            s5_q  <= red5;
            r0_q  <= rows[63:0];
            r1_q  <= rows[127:64];
            lo7_q <= sum_lo[31:0];
            c7_q  <= sum_lo[32];
            h0_q  <= r0_q[63:32];
            h1_q  <= r1_q[63:32];
            lo_q  <= lo7_q;
            hi_q  <= h0_q + h1_q + {31'b0, c7_q};
        end
    end

    assign lo = lo_q;
    assign hi = hi_q;
endmodule

// File: tb/tb_mul32_pipelined.sv
// tb_mul32_pipelined: directed table, mode-toggling stream and reset
// sequences for the 8-stage multiplier.
module tb_mul32_pipelined;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a, b;
    logic        mode;
    logic [31:0] lo, hi;

    mul32_pipelined #(.T(0.0)) dut (
        .clk (clk),
        .rst (rst),
        .a   (a),
        .b   (b),
        .mode(mode),
        .lo  (lo),
        .hi  (hi)
    );

    always #5 clk = ~clk;

`ifdef MUL32_SIGNED_MODE_EN
    localparam bit SGN = 1'b1;
`else
    localparam bit SGN = 1'b0;
`endif

    typedef struct {
        logic        m;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] pu;
        logic [63:0] ps;
    } vec_t;

    localparam int NT = 13;
    localparam int NR = 24;

    int n_run  = 0;
    int n_fail = 0;

    task automatic check(string name, logic [63:0] got, logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic logic [63:0] gold(logic [31:0] x, logic [31:0] y,
                                         logic m);
        logic signed [63:0] sx, sy;
        if (SGN && m) begin
            sx = {{32{x[31]}}, x};
            sy = {{32{y[31]}}, y};
            return sx * sy;
        end
        return {32'b0, x} * {32'b0, y};
    endfunction

    task automatic release_check(string tag, logic [63:0] exp);
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            if (i == 1) begin
                a = '0;
                b = '0;
            end
            check($sformatf("%s_e%0d", tag, i), {hi, lo},
                  (i == 8) ? exp : 64'd0);
        end
    endtask

    vec_t        tbl [NT];
    logic [31:0] ra [NR];
    logic [31:0] rb [NR];
    logic        rm [NR];

    initial begin
        tbl[0]  = '{1'b0, 32'd292, 32'd6785, 64'd1981220, 64'd1981220};
        tbl[1]  = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF,
                    64'hFFFFFFFE00000001, 64'hFFFFFFFE00000001};
        tbl[2]  = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF,
                    64'hFFFFFFFE00000001, 64'h0000000000000001};
        tbl[3]  = '{1'b1, 32'hFFFFFFFF, 32'h1,
                    64'h00000000FFFFFFFF, 64'hFFFFFFFFFFFFFFFF};
        tbl[4]  = '{1'b0, 32'hFFFFFFFF, 32'h1,
                    64'h00000000FFFFFFFF, 64'h00000000FFFFFFFF};
        tbl[5]  = '{1'b0, 32'h80000000, 32'h80000000,
                    64'h4000000000000000, 64'h4000000000000000};
        tbl[6]  = '{1'b1, 32'h80000000, 32'h80000000,
                    64'h4000000000000000, 64'h4000000000000000};
        tbl[7]  = '{1'b1, 32'h0, 32'h12345678, 64'd0, 64'd0};
        tbl[8]  = '{1'b0, 32'hDEADBEEF, 32'h0, 64'd0, 64'd0};
        tbl[9]  = '{1'b1, 32'h7FFFFFFF, 32'h7FFFFFFF,
                    64'h3FFFFFFF00000001, 64'h3FFFFFFF00000001};
        tbl[10] = '{1'b1, 32'h80000000, 32'h1,
                    64'h0000000080000000, 64'hFFFFFFFF80000000};
        tbl[11] = '{1'b1, 32'hFFFFFFFE, 32'h3,
                    64'h00000002FFFFFFFA, 64'hFFFFFFFFFFFFFFFA};
        tbl[12] = '{1'b0, 32'h00010000, 32'h00010000,
                    64'h0000000100000000, 64'h0000000100000000};

        rst = 1'b0;
        a = '0;
        b = '0;
        mode = 1'b0;
        #1 rst = 1'b1;
        #1 check("reset_async", {hi, lo}, 64'd0);
        repeat (2) @(negedge clk);
        check("reset_hold", {hi, lo}, 64'd0);
        a = 32'd5;
        b = 32'd7;
        rst = 1'b0;
        release_check("release", 64'd35);

        for (int t = 0; t < NT + 8; t++) begin
            @(negedge clk);
            if (t >= 8)
                check($sformatf("tbl%0d", t - 8), {hi, lo},
                      (SGN && tbl[t-8].m) ? tbl[t-8].ps : tbl[t-8].pu);
            if (t < NT) begin
                a = tbl[t].a;
                b = tbl[t].b;
                mode = tbl[t].m;
            end else begin
                a = '0;
                b = '0;
                mode = 1'b0;
            end
        end

        for (int i = 0; i < NR; i++) begin
            ra[i] = (i < 2) ? 32'h8FA4B672 : $urandom;
            rb[i] = (i < 2) ? 32'h6C3F8132 : $urandom;
            rm[i] = i[0];
        end
        for (int t = 0; t < NR + 8; t++) begin
            @(negedge clk);
            if (t >= 8)
                check($sformatf("stream%0d", t - 8), {hi, lo},
                      gold(ra[t-8], rb[t-8], rm[t-8]));
            if (t < NR) begin
                a = ra[t];
                b = rb[t];
                mode = rm[t];
            end else begin
                a = '0;
                b = '0;
                mode = 1'b0;
            end
        end

        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (t >= 8)
                check($sformatf("fill%0d", t - 8), {hi, lo},
                      gold(32'h1000 + 32'(t - 8), 32'h77 + 32'(t - 8),
                           1'((t - 8) % 2)));
            a = 32'h1000 + 32'(t);
            b = 32'h77 + 32'(t);
            mode = 1'(t % 2);
        end
        #2 rst = 1'b1;
        #1 check("midrst_now", {hi, lo}, 64'd0);
        @(negedge clk);
        check("midrst_hold", {hi, lo}, 64'd0);
        a = 32'd11;
        b = 32'd13;
        mode = 1'b1;
        rst = 1'b0;
        release_check("midrel", 64'd143);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
